// File: rtl/cache_ctrl.sv
// Direct-mapped write-through cache controller with a last-write filter.
// Define CACHE_STATS_EN to add saturating hit/miss counters and their ports.
module cache_ctrl #(
  parameter int LINES = 16,
  parameter int TAG_W = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic [8:0]  address,
  input  logic [31:0] write_data,
  output logic [31:0] fetched_data,
  output logic        stall_cpu,
  output logic        mem_req,
  output logic        mem_we,
  output logic [8:0]  mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);
  localparam int IDX_W = $clog2(LINES);

  typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_e;

  state_e                state_q, state_d;
  logic [LINES-1:0]      valid_q, valid_d;
  logic [TAG_W-1:0]      tag_q  [LINES];
  logic [TAG_W-1:0]      tag_d  [LINES];
  logic [31:0]           data_q [LINES];
  logic [31:0]           data_d [LINES];
  logic                  lw_valid_q, lw_valid_d;
  logic [8:0]            lw_addr_q, lw_addr_d;
  logic [31:0]           lw_data_q, lw_data_d;
  logic [31:0]           fetched_data_q, fetched_data_d;
  logic [8:0]            addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;

  logic [IDX_W-1:0]      idx, req_idx;
  logic [TAG_W-1:0]      tag, req_tag;
  logic                  rd_only, read_hit, write_filt;

  assign idx     = address[IDX_W-1:0];
  assign tag     = address[8 -: TAG_W];
  assign req_idx = addr_q[IDX_W-1:0];
  assign req_tag = addr_q[8 -: TAG_W];

  // A write alongside a read always wins, so a read hit only counts for read-only requests.
  assign rd_only    = read & ~write;
  assign read_hit   = rd_only & valid_q[idx] & (tag_q[idx] == tag);
  assign write_filt = write & lw_valid_q & (lw_addr_q == address) & (lw_data_q == write_data);

  assign stall_cpu    = (state_q != IDLE) | ((read | write) & ~read_hit & ~write_filt);
  assign mem_req      = (state_q != IDLE);
  assign mem_we       = (state_q == WR_THRU);
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign fetched_data = fetched_data_q;

  always_comb begin
    state_d        = state_q;
    valid_d        = valid_q;
    tag_d          = tag_q;
    data_d         = data_q;
    lw_valid_d     = lw_valid_q;
    lw_addr_d      = lw_addr_q;
    lw_data_d      = lw_data_q;
    fetched_data_d = fetched_data_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    case (state_q)
      IDLE: begin
        if (write && !write_filt) begin
          state_d = WR_THRU;
          addr_d  = address;
          wdata_d = write_data;
        end else if (rd_only && !read_hit) begin
          state_d = RD_MISS;
          addr_d  = address;
        end else if (read_hit) begin
          fetched_data_d = data_q[idx];
        end
      end
      RD_MISS: begin
        if (mem_ack) begin
          valid_d[req_idx] = 1'b1;
          tag_d[req_idx]   = req_tag;
          data_d[req_idx]  = mem_rdata;
          fetched_data_d   = mem_rdata;
          state_d          = IDLE;
        end
      end
      WR_THRU: begin
        if (mem_ack) begin
          valid_d[req_idx] = 1'b1;
          tag_d[req_idx]   = req_tag;
          data_d[req_idx]  = wdata_q;
          lw_valid_d       = 1'b1;
          lw_addr_d        = addr_q;
          lw_data_d        = wdata_q;
          state_d          = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      valid_q        <= '0;
      lw_valid_q     <= 1'b0;
      lw_addr_q      <= '0;
      lw_data_q      <= '0;
      fetched_data_q <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
    end else begin
      state_q        <= state_d;
      valid_q        <= valid_d;
      lw_valid_q     <= lw_valid_d;
      lw_addr_q      <= lw_addr_d;
      lw_data_q      <= lw_data_d;
      fetched_data_q <= fetched_data_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
    end
  end

  // Tag/data storage is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

`ifdef CACHE_STATS_EN
  logic [15:0] hit_count_q, hit_count_d;
  logic [15:0] miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (state_q == IDLE && read_hit && hit_count_q != 16'hFFFF)
      hit_count_d = hit_count_q + 16'd1;
    if (state_q == IDLE && rd_only && !read_hit && miss_count_q != 16'hFFFF)
      miss_count_d = miss_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif
endmodule
